serial_adder_unit: RTL and testbench

- Bit-serial add/subtract engine for the NTP datapath.
- Wraps a single one-bit full-adder cell with a carry flip-flop and operand/result shift registers, processing one bit per clock, LSB first.
- Consumes the cell's carryout every cycle and feeds it back as carryin.
- Used where area matters more than latency, for example address increment and the multi-cycle ALU path.

---
 rtl/ntp_alu_pkg.sv | 15 +
 rtl/Full_adder.sv | 19 +
 rtl/serial_adder_unit.sv | 161 ++++++++++++++++
 tb/tb_serial_adder_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntp_alu_pkg.sv
// ntp_alu_pkg
//   Definitions shared by the NTP arithmetic datapath blocks.
//   - DATA_W       : default datapath width
//   - S_IDLE/S_RUN/S_DONE : control state encodings for the serial engines
package ntp_alu_pkg;

  localparam int DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/Full_adder.sv
// Full_adder
//   One-bit full-adder cell.
//   Ports:
//     sum      : x ^ y ^ carryin
//     carryout : majority(x, y, carryin)
//     x, y     : operand bits
//     carryin  : incoming carry
module Full_adder (
  output logic sum,
  output logic carryout,
  input  logic x,
  input  logic y,
  input  logic carryin
);

  assign sum      = x ^ y ^ carryin;
  assign carryout = (x & y) | (carryin & (x ^ y));

endmodule

// File: rtl/serial_adder_unit.sv
// serial_adder_unit
//   Bit-serial add/subtract engine. One bit is processed per clock, LSB
//   first, through a single Full_adder cell whose carryout is registered
//   and fed back as the next carryin. A result is ready WIDTH clocks after
//   an accepted start.
//   Ports:
//     clk      : system clock, rising edge
//     reset    : synchronous active-high reset
//     start    : request pulse, accepted only in IDLE or DONE
//     a, b     : operands, captured on an accepted start
//     cin      : carry-in for add mode, captured on an accepted start
//     sub      : 1 = compute a - b, captured on an accepted start
//     sum      : result, held from done until the next accepted start
//     cout     : final carry-out (sub mode: 1 = no borrow)
//     overflow : signed overflow
//     zero     : sum == 0
//     busy     : bits are being processed
//     done     : one-cycle completion pulse
module serial_adder_unit
  import ntp_alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_sum;
  logic fa_carryout;
  logic accept;
  logic running;
  logic last_bit;

  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign running  = (state_q == S_RUN);
  assign last_bit = running && (cnt_q == CNT_LAST);

  Full_adder u_fa (
    .sum      (fa_sum),
    .carryout (fa_carryout),
    .x        (a_sh_q[0]),
    .y        (b_sh_q[0]),
    .carryin  (carry_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    if (accept) begin
      // Subtraction is A + ~B + 1: invert B and preset the carry to 1.
      a_sh_d  = a;
      b_sh_d  = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end else if (running) begin
      carry_d = fa_carryout;
      res_d   = {fa_sum, res_q[WIDTH-1:1]};
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_bit) begin
        cout_d = fa_carryout;
        // carry_q here is the carry into the MSB position.
        ovf_d  = carry_q ^ fa_carryout;
        zero_d = (res_d == '0);
      end
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum      = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// tb_serial_adder_unit
//   Directed bench for serial_adder_unit at WIDTH=8. Inputs are driven 1
//   time unit after the rising edge and outputs are sampled at that point.
module tb_serial_adder_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;
  logic       zero;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  serial_adder_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a start pulse across one rising edge (the start edge E0).
  task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv);
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Step until done is seen (bounded); counts clocks since the start edge
  // and the number of in-flight cycles where busy was not high.
  task automatic wait_done(output int cyc, output int busy_bad);
    cyc = 0;
    busy_bad = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sum, cout, overflow, zero, busy, done} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b zero=%b busy=%b done=%b, expected all 0",
               sum, cout, overflow, zero, busy, done);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    $display("reset: outputs cleared, idle");
  endtask

  task automatic test_add_basic;
    int cyc, busy_bad;
    launch(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done(cyc, busy_bad);
    checks++;
    if (cyc !== 8) begin
      failures++;
      $display("FAIL basic_latency: got %0d clocks, expected 8", cyc);
    end
    checks++;
    if (busy_bad !== 0) begin
      failures++;
      $display("FAIL basic_busy: busy low in %0d in-flight cycles, expected 0", busy_bad);
    end
    checks++;
    if (sum !== 8'h4B || cout !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got sum=%h cout=%b ovf=%b zero=%b busy=%b, expected 4b 0 0 0 0",
               sum, cout, overflow, zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || sum !== 8'h4B) begin
      failures++;
      $display("FAIL basic_hold: got done=%b sum=%h, expected 0 4b", done, sum);
    end
    $display("add 3c+0f: sum=%h cout=%b ovf=%b zero=%b after %0d clocks", sum, cout, overflow, zero, cyc);
  endtask

  typedef struct {
    logic [7:0] av;
    logic [7:0] bv;
    logic       cv;
    logic       sv;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
    logic       exp_zero;
  } vec_t;

  task automatic test_flags;
    vec_t vecs[6];
    int cyc, busy_bad;
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h33, 8'h33, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].av, vecs[i].bv, vecs[i].cv, vecs[i].sv);
      wait_done(cyc, busy_bad);
      checks++;
      if (cyc !== 8) begin
        failures++;
        $display("FAIL flags_latency[%0d]: got %0d clocks, expected 8", i, cyc);
      end
      checks++;
      if (sum !== vecs[i].exp_sum) begin
        failures++;
        $display("FAIL flags_sum[%0d]: got %h, expected %h", i, sum, vecs[i].exp_sum);
      end
      checks++;
      if (cout !== vecs[i].exp_cout || overflow !== vecs[i].exp_ovf || zero !== vecs[i].exp_zero) begin
        failures++;
        $display("FAIL flags_bits[%0d]: got cout=%b ovf=%b zero=%b, expected %b %b %b", i,
                 cout, overflow, zero, vecs[i].exp_cout, vecs[i].exp_ovf, vecs[i].exp_zero);
      end
      $display("vec %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b",
               i, vecs[i].av, vecs[i].bv, vecs[i].cv, vecs[i].sv, sum, cout, overflow, zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int done_cnt, first_done;
    done_cnt = 0;
    first_done = -1;
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == 3) begin
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
        a = 8'hC3; b = 8'h3C;
      end
      if (k == 8) begin
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0 || zero !== 1'b0) begin
          failures++;
          $display("FAIL ignore_result: got sum=%h cout=%b zero=%b, expected 30 0 0", sum, cout, zero);
        end
      end
    end
    checks++;
    if (done_cnt !== 1 || first_done !== 8) begin
      failures++;
      $display("FAIL ignore_done: got %0d pulses first at %0d, expected 1 at 8", done_cnt, first_done);
    end
    sub = 1'b0;
    $display("start during run: done pulses=%0d sum=%h", done_cnt, sum);
  endtask

  task automatic test_reset_mid_run;
    int done_cnt, cyc, busy_bad;
    done_cnt = 0;
    launch(8'h3C, 8'h0F, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({sum, cout, overflow, zero, busy, done} !== 12'h000) begin
      failures++;
      $display("FAIL midrun_reset: got sum=%h cout=%b ovf=%b zero=%b busy=%b done=%b, expected all 0",
               sum, cout, overflow, zero, busy, done);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL midrun_no_done: got %0d active cycles after abort, expected 0", done_cnt);
    end
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done(cyc, busy_bad);
    checks++;
    if (cyc !== 8 || busy_bad !== 0 || sum !== 8'h46) begin
      failures++;
      $display("FAIL midrun_fresh: got %0d clocks busy_bad=%0d sum=%h, expected 8 0 46", cyc, busy_bad, sum);
    end
    $display("reset mid-run: aborted cleanly, fresh op sum=%h after %0d clocks", sum, cyc);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc, busy_bad;
    launch(8'h20, 8'h22, 1'b0, 1'b0);
    wait_done(cyc, busy_bad);
    checks++;
    if (cyc !== 8 || sum !== 8'h42) begin
      failures++;
      $display("FAIL b2b_first: got %0d clocks sum=%h, expected 8 42", cyc, sum);
    end
    // Still in the DONE cycle: this start is taken on the edge that ends it.
    launch(8'h01, 8'h01, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_chain: got busy=%b done=%b, expected 1 0", busy, done);
    end
    wait_done(cyc, busy_bad);
    checks++;
    if (cyc !== 8 || busy_bad !== 0) begin
      failures++;
      $display("FAIL b2b_latency: got %0d clocks busy_bad=%0d, expected 8 0", cyc, busy_bad);
    end
    checks++;
    if (sum !== 8'h02 || cout !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_result: got sum=%h cout=%b zero=%b, expected 02 0 0", sum, cout, zero);
    end
    $display("back-to-back: second sum=%h after %0d clocks", sum, cyc);
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    checks = 0;
    failures = 0;

    test_reset;
    test_add_basic;
    test_flags;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
